// File: rtl/my_alu_seq.sv
// Registered 74181-style ALU with stored-carry chaining and a one-cycle DONE strobe.
// Define MY_ALU_MUL_EN to add the iterative unsigned shift-add multiplier (MUL=1 requests).
module my_alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [3:0]       S,
  input  logic             M,
  input  logic             CN,
  input  logic             CSEL,
  input  logic             MUL,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] FH,
  output logic             CO,
  output logic             ZF,
  output logic             EQ,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned XW = WIDTH + 1;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] r_f;
  logic [WIDTH-1:0] r_fh;
  logic             r_co;
  logic             r_zf;
  logic             r_eq;
  logic             r_done;

  logic             w_cin;
  logic [XW-1:0]    w_a;
  logic [XW-1:0]    w_b;
  logic [XW-1:0]    w_nb;
  logic [XW-1:0]    w_c;
  logic [XW-1:0]    w_arith;
  logic [WIDTH-1:0] w_logic;
  logic [WIDTH-1:0] w_f;
  logic             w_co;

  logic             w_alu_go;
  logic             w_mul_go;
  logic             w_mul_last;
  logic             w_mul_eq;
  logic [PW-1:0]    w_prod;

  assign w_cin = CSEL ? r_co : CN;
  assign w_a   = {1'b0, A};
  assign w_b   = {1'b0, B};
  assign w_nb  = {1'b0, ~B};
  assign w_c   = XW'(w_cin);

  // Arithmetic at WIDTH+1 bits so the top bit is the carry/borrow
  always_comb begin
    w_arith = '0;
    case (S)
      4'h0: w_arith = w_a + w_c;
      4'h1: w_arith = (w_a | w_b) + w_c;
      4'h2: w_arith = (w_a | w_nb) + w_c;
      4'h3: w_arith = XW'(0) - w_c;
      4'h4: w_arith = w_a + (w_a & w_nb) + w_c;
      4'h5: w_arith = (w_a | w_b) + (w_a & w_nb) + w_c;
      4'h6: w_arith = w_a - w_b - w_c;
      4'h7: w_arith = (w_a & w_nb) - w_c;
      4'h8: w_arith = w_a + (w_a & w_b) + w_c;
      4'h9: w_arith = w_a + w_b + w_c;
      4'hA: w_arith = (w_a | w_nb) + (w_a & w_b) + w_c;
      4'hB: w_arith = (w_a & w_b) - w_c;
      4'hC: w_arith = w_a + w_a + w_c;
      4'hD: w_arith = (w_a | w_b) + w_a + w_c;
      4'hE: w_arith = (w_a | w_nb) + w_a + w_c;
      4'hF: w_arith = w_a - w_c;
      default: w_arith = '0;
    endcase
  end

  always_comb begin
    w_logic = '0;
    case (S)
      4'h0: w_logic = ~A;
      4'h1: w_logic = ~(A | B);
      4'h2: w_logic = ~A & B;
      4'h3: w_logic = '0;
      4'h4: w_logic = ~(A & B);
      4'h5: w_logic = ~B;
      4'h6: w_logic = A ^ B;
      4'h7: w_logic = A & ~B;
      4'h8: w_logic = ~A | B;
      4'h9: w_logic = ~(A ^ B);
      4'hA: w_logic = B;
      4'hB: w_logic = A & B;
      4'hC: w_logic = '1;
      4'hD: w_logic = A | ~B;
      4'hE: w_logic = A | B;
      4'hF: w_logic = A;
      default: w_logic = '0;
    endcase
  end

  assign w_f  = M ? w_logic : w_arith[WIDTH-1:0];
  assign w_co = M ? 1'b0 : w_arith[WIDTH];

`ifdef MY_ALU_MUL_EN
  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_mul_eq;

  assign w_alu_go   = START & ~MUL & (r_state == ST_IDLE);
  assign w_mul_go   = START & MUL & (r_state == ST_IDLE);
  assign w_mul_last = (r_state == ST_RUN) && (r_cnt == CW'(WIDTH - 1));
  assign w_prod     = r_acc + (r_mplier[0] ? r_mcand : PW'(0));
  assign w_mul_eq   = r_mul_eq;
  assign BUSY       = (r_state == ST_RUN);

  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_mul_go)   w_state_nxt = ST_RUN;
      ST_RUN:  if (w_mul_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // One partial product per cycle; WIDTH steps complete the product
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_mul_eq <= 1'b0;
    end else if (w_mul_go) begin
      r_mcand  <= PW'(A);
      r_mplier <= B;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_mul_eq <= (A == B);
    end else if (r_state == ST_RUN) begin
      r_acc    <= w_prod;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
    end
  end
`else
  logic w_unused_mul;

  assign w_unused_mul = MUL;
  assign w_alu_go     = START;
  assign w_mul_go     = 1'b0;
  assign w_mul_last   = 1'b0;
  assign w_mul_eq     = 1'b0;
  assign w_prod       = '0;
  assign BUSY         = 1'b0;
`endif

  // Result and flag registers; held between DONE pulses
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_f    <= '0;
      r_fh   <= '0;
      r_co   <= 1'b0;
      r_zf   <= 1'b0;
      r_eq   <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_alu_go) begin
        r_f    <= w_f;
        r_fh   <= '0;
        r_co   <= w_co;
        r_zf   <= (w_f == '0);
        r_eq   <= (A == B);
        r_done <= 1'b1;
      end else if (w_mul_last) begin
        r_f    <= w_prod[WIDTH-1:0];
        r_fh   <= w_prod[PW-1:WIDTH];
        r_co   <= 1'b0;
        r_zf   <= (w_prod == '0);
        r_eq   <= w_mul_eq;
        r_done <= 1'b1;
      end
    end
  end

  assign F    = r_f;
  assign FH   = r_fh;
  assign CO   = r_co;
  assign ZF   = r_zf;
  assign EQ   = r_eq;
  assign DONE = r_done;

endmodule

// File: tb/tb_my_alu_seq.sv
// Scoreboard bench for my_alu_seq (WIDTH=8); multiplier cases run when MY_ALU_MUL_EN is defined.
module tb_my_alu_seq;

  logic       CLK, RST, START, M, CN, CSEL, MUL;
  logic [3:0] S;
  logic [7:0] A, B, F, FH;
  logic       CO, ZF, EQ, BUSY, DONE;

  int total = 0;
  int bad   = 0;
  int n_push = 0;
  int n_done = 0;

  typedef struct {
    string      nm;
    logic [7:0] f;
    logic [7:0] fh;
    logic       co;
    logic       zf;
    logic       eq;
  } exp_t;

  typedef struct {
    logic [3:0] s;
    logic       m, cn, csel;
    logic [7:0] a, b, f;
    logic       co, zf, eq;
  } vec_t;

  exp_t q[$];
  vec_t vecs[25];

  my_alu_seq #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .START(START), .S(S), .M(M), .CN(CN), .CSEL(CSEL),
    .MUL(MUL), .A(A), .B(B), .F(F), .FH(FH), .CO(CO), .ZF(ZF), .EQ(EQ),
    .BUSY(BUSY), .DONE(DONE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input string nm, input logic [7:0] f, input logic [7:0] fh,
                      input logic co, input logic zf, input logic eq);
    exp_t e;
    e.nm = nm; e.f = f; e.fh = fh; e.co = co; e.zf = zf; e.eq = eq;
    q.push_back(e);
    n_push++;
  endtask

  task automatic issue(input logic [3:0] s, input logic m, input logic cn, input logic csel,
                       input logic mul, input logic [7:0] a, input logic [7:0] b);
    S = s; M = m; CN = cn; CSEL = csel; MUL = mul; A = a; B = b; START = 1'b1;
    tick();
    START = 1'b0; CSEL = 1'b0; MUL = 1'b0;
  endtask

  // Monitor: every DONE cycle must match the oldest outstanding expectation
  always @(negedge CLK) begin
    if (DONE === 1'b1) begin
      n_done++;
      if (q.size() == 0) begin
        chk("unexpected_done", 16'(DONE), 16'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.nm, "_F"},  16'(F),  16'(e.f));
        chk({e.nm, "_FH"}, 16'(FH), 16'(e.fh));
        chk({e.nm, "_CO"}, 16'(CO), 16'(e.co));
        chk({e.nm, "_ZF"}, 16'(ZF), 16'(e.zf));
        chk({e.nm, "_EQ"}, 16'(EQ), 16'(e.eq));
      end
    end
  end

  initial begin
    //          s     m  cn csel a      b      f      co zf eq
    vecs = '{
      '{4'h9, 0, 0, 0, 8'hFF, 8'h01, 8'h00, 1, 1, 0},
      '{4'h9, 0, 0, 1, 8'h00, 8'h00, 8'h01, 0, 0, 1},
      '{4'h6, 0, 0, 0, 8'h05, 8'h07, 8'hFE, 1, 0, 0},
      '{4'h6, 1, 0, 0, 8'hF0, 8'h3C, 8'hCC, 0, 0, 0},
      '{4'h0, 0, 1, 0, 8'hFF, 8'h00, 8'h00, 1, 1, 0},
      '{4'h3, 0, 1, 0, 8'h12, 8'h34, 8'hFF, 1, 0, 0},
      '{4'h3, 0, 0, 0, 8'h12, 8'h12, 8'h00, 0, 1, 1},
      '{4'h6, 0, 1, 0, 8'h10, 8'h10, 8'hFF, 1, 0, 1},
      '{4'hC, 0, 0, 0, 8'h80, 8'h00, 8'h00, 1, 1, 0},
      '{4'h2, 0, 0, 0, 8'h00, 8'h0F, 8'hF0, 0, 0, 0},
      '{4'hF, 0, 1, 0, 8'h00, 8'h00, 8'hFF, 1, 0, 1},
      '{4'h4, 0, 0, 0, 8'h0F, 8'h03, 8'h1B, 0, 0, 0},
      '{4'hB, 0, 1, 0, 8'h0C, 8'h0A, 8'h07, 0, 0, 0},
      '{4'h7, 0, 1, 0, 8'h03, 8'h03, 8'hFF, 1, 0, 1},
      '{4'hA, 0, 0, 0, 8'hF0, 8'h0F, 8'hF0, 0, 0, 0},
      '{4'h5, 0, 1, 0, 8'hAA, 8'h55, 8'hAA, 1, 0, 0},
      '{4'h8, 0, 0, 0, 8'h81, 8'h81, 8'h02, 1, 0, 1},
      '{4'hD, 0, 0, 0, 8'h80, 8'h01, 8'h01, 1, 0, 0},
      '{4'hE, 0, 0, 1, 8'h01, 8'hFF, 8'h03, 0, 0, 0},
      '{4'h1, 0, 1, 0, 8'h7F, 8'h80, 8'h00, 1, 1, 0},
      '{4'hC, 1, 1, 0, 8'h00, 8'h00, 8'hFF, 0, 0, 1},
      '{4'h9, 1, 0, 0, 8'hAA, 8'hAA, 8'hFF, 0, 0, 1},
      '{4'h3, 1, 0, 0, 8'h01, 8'h02, 8'h00, 0, 1, 0},
      '{4'h0, 1, 0, 0, 8'hFF, 8'h00, 8'h00, 0, 1, 0},
      '{4'h9, 0, 1, 1, 8'h01, 8'h01, 8'h02, 0, 0, 1}
    };

    RST = 1'b1; START = 1'b0; S = '0; M = 1'b0; CN = 1'b0; CSEL = 1'b0; MUL = 1'b0;
    A = '0; B = '0;
    tick();
    tick();
    chk("rst_F",    16'(F),    16'h0);
    chk("rst_FH",   16'(FH),   16'h0);
    chk("rst_CO",   16'(CO),   16'h0);
    chk("rst_ZF",   16'(ZF),   16'h0);
    chk("rst_EQ",   16'(EQ),   16'h0);
    chk("rst_BUSY", 16'(BUSY), 16'h0);
    chk("rst_DONE", 16'(DONE), 16'h0);
    RST = 1'b0;
    tick();

    // Back-to-back ALU ops, one per cycle
    for (int i = 0; i < 25; i++) begin
      push($sformatf("alu%0d", i), vecs[i].f, 8'h00, vecs[i].co, vecs[i].zf, vecs[i].eq);
      issue(vecs[i].s, vecs[i].m, vecs[i].cn, vecs[i].csel, 1'b0, vecs[i].a, vecs[i].b);
    end
    tick();
    tick();
    tick();
    chk("hold_F",    16'(F),    16'h02);
    chk("hold_EQ",   16'(EQ),   16'h1);
    chk("hold_DONE", 16'(DONE), 16'h0);

    // START together with reset: reset wins
    RST = 1'b1;
    issue(4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h01);
    chk("rst_start_F",    16'(F),    16'h0);
    chk("rst_start_EQ",   16'(EQ),   16'h0);
    chk("rst_start_DONE", 16'(DONE), 16'h0);
    RST = 1'b0;
    tick();
    chk("post_rst_DONE", 16'(DONE), 16'h0);

`ifdef MY_ALU_MUL_EN
    push("alu_pre_mul", 8'h02, 8'h00, 1'b0, 1'b0, 1'b1);
    issue(4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h01);

    push("mul_ffff", 8'h01, 8'hFE, 1'b0, 1'b0, 1'b1);
    issue(4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF);
    begin
      int busy_cycles = 0;
      for (int k = 0; k < 40 && BUSY === 1'b1; k++) begin
        busy_cycles++;
        if (k == 2) begin
          chk("busy_hold_F", 16'(F), 16'h02);
          S = 4'h9; M = 1'b0; A = 8'h11; B = 8'h22; START = 1'b1;
        end
        tick();
        START = 1'b0;
      end
      chk("mul_busy_cycles", 16'(busy_cycles), 16'd8);
      chk("mul_busy_end",    16'(BUSY),        16'h0);
    end
    tick();
    tick();

    // Reset in the third cycle of a multiply aborts it
    issue(4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 8'h05);
    tick();
    tick();
    RST = 1'b1;
    tick();
    chk("abort_F",    16'(F),    16'h0);
    chk("abort_FH",   16'(FH),   16'h0);
    chk("abort_ZF",   16'(ZF),   16'h0);
    chk("abort_EQ",   16'(EQ),   16'h0);
    chk("abort_BUSY", 16'(BUSY), 16'h0);
    chk("abort_DONE", 16'(DONE), 16'h0);
    RST = 1'b0;
    for (int k = 0; k < 12; k++) tick();

    push("mul_0305", 8'h0F, 8'h00, 1'b0, 1'b0, 1'b0);
    issue(4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 8'h05);
    for (int k = 0; k < 20 && q.size() != 0; k++) tick();
`else
    // Without the multiplier a MUL request is an ordinary ALU op
    push("mul_as_alu", 8'h02, 8'h00, 1'b0, 1'b0, 1'b1);
    issue(4'h9, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 8'h01);
    chk("nomul_BUSY", 16'(BUSY), 16'h0);
    tick();
    chk("nomul_FH", 16'(FH), 16'h0);
`endif

    tick();
    tick();
    chk("queue_drained", 16'(q.size()), 16'h0);
    chk("done_count",    16'(n_done),   16'(n_push));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
